// File: rtl/pwm_rx_multi.sv
// pwm_rx_multi: multi-channel PWM receiver measuring high time and period, with loss-of-signal timeout.
// Optional 3-sample majority glitch filter after the synchronizer: define PWM_RX_GLITCH_FILTER_EN.
//
//   state | meaning
//   IDLE  | no valid edge reference yet (after reset or timeout); counting missing-edge cycles
//   HIGH  | inside a high pulse, counting high time and period
//   SAT   | high time hit full scale; wait for the falling edge without further updates
//   LOW   | between pulses, counting period and missing-edge cycles
module pwm_rx_multi #(
   parameter int CH      = 4,
   parameter int CNT_W   = 10,
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CH-1:0]       pwm,
   output logic [CH*CNT_W-1:0] Position,
   output logic [CH*CNT_W-1:0] Period,
   output logic [CH-1:0]       upd,
   output logic [CH-1:0]       lost
);

   localparam int               TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_SAT
   } state_t;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic             sync1_q, sync2_q, s;
      state_t           state_q;
      logic [CNT_W-1:0] hcnt_q, pcnt_q, pos_q, per_q, pcnt_d;
      logic [TW-1:0]    tcnt_q;
      logic             upd_q, lost_q, tmo;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
         end else begin
            sync1_q <= pwm[i];
            sync2_q <= sync1_q;
         end
      end

`ifdef PWM_RX_GLITCH_FILTER_EN
      logic [1:0] hist_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            hist_q <= 2'b00;
         end else begin
            hist_q <= {hist_q[0], sync2_q};
         end
      end

      // Majority over the current and two previous synchronized samples: one cycle of extra delay.
      assign s = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
      assign s = sync2_q;
`endif

      assign pcnt_d = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + 1'b1;
      assign tmo    = (tcnt_q == T_LAST);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
            pos_q   <= '0;
            per_q   <= '0;
            upd_q   <= 1'b0;
            lost_q  <= 1'b0;
         end else begin
            upd_q <= 1'b0;
            unique case (state_q)
               ST_IDLE: begin
                  if (s) begin
                     state_q <= ST_HIGH;
                     hcnt_q  <= CNT_ONE;
                     pcnt_q  <= CNT_ONE;
                     tcnt_q  <= '0;
                     lost_q  <= 1'b0;
                  end else if (tmo) begin
                     // tcnt is held here, so this repeats harmlessly while the line stays dead.
                     pos_q  <= '0;
                     per_q  <= '0;
                     lost_q <= 1'b1;
                     upd_q  <= (pos_q != '0);
                  end else begin
                     tcnt_q <= tcnt_q + 1'b1;
                  end
               end
               ST_HIGH: begin
                  pcnt_q <= pcnt_d;
                  if (!s) begin
                     state_q <= ST_LOW;
                     pos_q   <= hcnt_q;
                     upd_q   <= 1'b1;
                  end else if (hcnt_q == CNT_MAX) begin
                     state_q <= ST_SAT;
                     pos_q   <= CNT_MAX;
                     upd_q   <= 1'b1;
                  end else begin
                     hcnt_q <= hcnt_q + 1'b1;
                  end
               end
               ST_SAT: begin
                  pcnt_q <= pcnt_d;
                  if (!s) begin
                     state_q <= ST_LOW;
                  end
               end
               ST_LOW: begin
                  if (s) begin
                     state_q <= ST_HIGH;
                     per_q   <= pcnt_q;
                     hcnt_q  <= CNT_ONE;
                     pcnt_q  <= CNT_ONE;
                     tcnt_q  <= '0;
                     lost_q  <= 1'b0;
                  end else if (tmo) begin
                     state_q <= ST_IDLE;
                     pos_q   <= '0;
                     per_q   <= '0;
                     lost_q  <= 1'b1;
                     upd_q   <= (pos_q != '0);
                  end else begin
                     pcnt_q <= pcnt_d;
                     tcnt_q <= tcnt_q + 1'b1;
                  end
               end
            endcase
         end
      end

      assign Position[i*CNT_W +: CNT_W] = pos_q;
      assign Period[i*CNT_W +: CNT_W]   = per_q;
      assign upd[i]                     = upd_q;
      assign lost[i]                    = lost_q;
   end

endmodule

// File: tb/tb_pwm_rx_multi.sv
// Bench for pwm_rx_multi: edge-timestamp reference model compared every cycle, plus directed literal checks.
// Honours PWM_RX_GLITCH_FILTER_EN when the design is built with it.
module tb_pwm_rx_multi;
   localparam int CH   = 2;
   localparam int CW   = 10;
   localparam int TO   = 1024;
   localparam int MAXV = (1 << CW) - 1;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [CH-1:0]       pwm;
   logic [CH*CW-1:0]    Position, Period;
   logic [CH-1:0]       upd, lost;

   always #5 clk = ~clk;

   pwm_rx_multi #(.CH(CH), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .pwm      (pwm),
      .Position (Position),
      .Period   (Period),
      .upd      (upd),
      .lost     (lost)
   );

   // Reference model: time-stamps of synchronized edges, counted in non-reset clock edges.
   int   kcyc = 0;
   logic [3:0] smp [CH];
   logic s_prev [CH];
   int   hi_start [CH];
   int   quiet_start [CH];
   bit   per_valid [CH];
   int   m_pos [CH];
   int   m_per [CH];
   bit   m_upd [CH];
   bit   m_lost [CH];

   always @(posedge clk or negedge reset_n) begin
      logic sv;
      int   n;
      if (!reset_n) begin
         for (int c = 0; c < CH; c++) begin
            smp[c] = '0; s_prev[c] = 1'b0; hi_start[c] = 0; quiet_start[c] = kcyc;
            per_valid[c] = 1'b0; m_pos[c] = 0; m_per[c] = 0; m_upd[c] = 1'b0; m_lost[c] = 1'b0;
         end
      end else begin
         kcyc++;
         for (int c = 0; c < CH; c++) begin
`ifdef PWM_RX_GLITCH_FILTER_EN
            sv = ((int'(smp[c][1]) + int'(smp[c][2]) + int'(smp[c][3])) >= 2);
`else
            sv = smp[c][1];
`endif
            smp[c] = {smp[c][2:0], pwm[c]};
            m_upd[c] = 1'b0;
            if (sv && !s_prev[c]) begin
               if (per_valid[c]) m_per[c] = (kcyc - hi_start[c] < MAXV) ? kcyc - hi_start[c] : MAXV;
               hi_start[c] = kcyc; per_valid[c] = 1'b1; m_lost[c] = 1'b0;
            end else if (sv && s_prev[c]) begin
               if (kcyc - hi_start[c] == MAXV) begin m_pos[c] = MAXV; m_upd[c] = 1'b1; end
            end else if (!sv && s_prev[c]) begin
               n = kcyc - hi_start[c];
               if (n <= MAXV) begin m_pos[c] = n; m_upd[c] = 1'b1; end
               quiet_start[c] = kcyc;
            end else if (kcyc - quiet_start[c] >= TO) begin
               m_upd[c] = (m_pos[c] != 0);
               m_pos[c] = 0; m_per[c] = 0; m_lost[c] = 1'b1; per_valid[c] = 1'b0;
            end
            s_prev[c] = sv;
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;
   int upd_cnt [CH];

   task automatic cmp_cycle();
      logic [CH*CW-1:0] ep, eper;
      logic [CH-1:0]    eu, el;
      for (int c = 0; c < CH; c++) begin
         ep[c*CW +: CW]   = CW'(m_pos[c]);
         eper[c*CW +: CW] = CW'(m_per[c]);
         eu[c] = m_upd[c];
         el[c] = m_lost[c];
      end
      n_cmp++;
      if ({Position, Period, upd, lost} !== {ep, eper, eu, el}) begin
         n_err++;
         $display("FAIL cycle_cmp t=%0t: Position %h want %h, Period %h want %h, upd %b want %b, lost %b want %b",
                  $time, Position, ep, Period, eper, upd, eu, lost, el);
      end
      for (int c = 0; c < CH; c++) if (upd[c] === 1'b1) upd_cnt[c]++;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic int pos_of(input int c);
      return int'(Position[c*CW +: CW]);
   endfunction

   function automatic int per_of(input int c);
      return int'(Period[c*CW +: CW]);
   endfunction

   int u0, u1;

   initial begin
      for (int c = 0; c < CH; c++) upd_cnt[c] = 0;
      reset_n = 1'b1;
      pwm     = '0;
      #1 reset_n = 1'b0;
      fork
         begin
            step(3);
            chk("reset_position", int'(Position), 0);
            chk("reset_period", int'(Period), 0);
            chk("reset_upd", int'(upd), 0);
            chk("reset_lost", int'(lost), 0);
            reset_n = 1'b1;

            // 300 high / 700 low on channel 0
            for (int r = 0; r < 3; r++) begin
               pwm[0] = 1'b1; step(300);
               pwm[0] = 1'b0; step(700);
            end
            pwm[0] = 1'b1; step(300);
            pwm[0] = 1'b0; step(10);
            chk("pos0_300", pos_of(0), 300);
            chk("per0_1000", per_of(0), 1000);
            chk("model_pos0_300", m_pos[0], 300);
            chk("model_per0_1000", m_per[0], 1000);
            chk("upd0_count_4", upd_cnt[0], 4);
            chk("pos1_untouched", pos_of(1), 0);

            // loss of signal on channel 0, then recovery
            u0 = upd_cnt[0];
            step(1100);
            chk("timeout_pos0", pos_of(0), 0);
            chk("timeout_per0", per_of(0), 0);
            chk("timeout_lost0", int'(lost[0]), 1);
            chk("timeout_upd0_once", upd_cnt[0] - u0, 1);
            pwm[0] = 1'b1; step(50);
            pwm[0] = 1'b0; step(10);
            chk("recover_lost0", int'(lost[0]), 0);
            chk("recover_pos0_50", pos_of(0), 50);

            // saturation on channel 1
            u1 = upd_cnt[1];
            pwm[1] = 1'b1; step(2000);
            chk("sat_pos1", pos_of(1), 1023);
            chk("model_pos1_sat", m_pos[1], 1023);
            chk("sat_upd1_once", upd_cnt[1] - u1, 1);
            pwm[1] = 1'b0; step(100);
            pwm[1] = 1'b1; step(5);
            chk("sat_per1", per_of(1), 1023);
            pwm[1] = 1'b0; step(10);

            // simultaneous channels, fall-to-update latency
            pwm = 2'b11; step(400);
            pwm = 2'b00;
            @(posedge clk); #1 chk("lat_edge1_upd", int'(upd), 0);
            @(posedge clk); #1 chk("lat_edge2_upd", int'(upd), 0);
`ifdef PWM_RX_GLITCH_FILTER_EN
            @(posedge clk); #1 chk("lat_edge3_upd_filt", int'(upd), 0);
`endif
            @(posedge clk); #1 chk("lat_both_upd", int'(upd), 3);
            chk("both_pos0_400", pos_of(0), 400);
            chk("both_pos1_400", pos_of(1), 400);
            step(10);

            // reset in the middle of a pulse
            pwm[0] = 1'b1; step(150);
            #1 reset_n = 1'b0;
            #1;
            chk("midrst_position", int'(Position), 0);
            chk("midrst_period", int'(Period), 0);
            chk("midrst_upd", int'(upd), 0);
            chk("midrst_lost", int'(lost), 0);
            step(3);
            reset_n = 1'b1;
            u0 = upd_cnt[0];
            step(147);
            pwm[0] = 1'b0; step(10);
            chk("partial_pos0_147", pos_of(0), 147);
            chk("partial_per0", per_of(0), 0);
            chk("partial_upd0_once", upd_cnt[0] - u0, 1);

            // one-cycle glitch, then a 20-cycle pulse
            u0 = upd_cnt[0];
            pwm[0] = 1'b1; step(1);
            pwm[0] = 1'b0; step(10);
`ifdef PWM_RX_GLITCH_FILTER_EN
            chk("glitch_pos0_kept", pos_of(0), 147);
            chk("glitch_no_upd", upd_cnt[0] - u0, 0);
`else
            chk("glitch_pos0_1", pos_of(0), 1);
            chk("glitch_upd_once", upd_cnt[0] - u0, 1);
`endif
            pwm[0] = 1'b1; step(20);
            pwm[0] = 1'b0; step(10);
            chk("pulse_pos0_20", pos_of(0), 20);
         end
         begin
            forever begin
               @(negedge clk);
               cmp_cycle();
            end
         end
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
